// File: rtl/location_pkg.sv
// Shared definitions for the seven-room adventure location tracker:
// room index constants, the one-hot room state type and small helpers
// for index conversion and one-hot integrity checking.
package location_pkg;

    localparam int NUM_ROOMS = 7;

    // Binary room indices, also the value carried by state_idx
    localparam logic [2:0] ROOM_CAVE   = 3'd0;
    localparam logic [2:0] ROOM_TUNNEL = 3'd1;
    localparam logic [2:0] ROOM_RIVER  = 3'd2;
    localparam logic [2:0] ROOM_STASH  = 3'd3;
    localparam logic [2:0] ROOM_DRAGON = 3'd4;
    localparam logic [2:0] ROOM_VAULT  = 3'd5;
    localparam logic [2:0] ROOM_GRAVE  = 3'd6;

    // One-hot room state; bit position equals the room index
    typedef enum logic [NUM_ROOMS-1:0] {
        ST_CAVE   = 7'b000_0001,
        ST_TUNNEL = 7'b000_0010,
        ST_RIVER  = 7'b000_0100,
        ST_STASH  = 7'b000_1000,
        ST_DRAGON = 7'b001_0000,
        ST_VAULT  = 7'b010_0000,
        ST_GRAVE  = 7'b100_0000
    } room_state_t;

    // True when exactly one bit of the state vector is set
    function automatic logic is_onehot(input logic [NUM_ROOMS-1:0] vec);
        logic [2:0] ones;
        ones = 3'd0;
        for (int i = 0; i < NUM_ROOMS; i++) begin
            ones = ones + {2'b00, vec[i]};
        end
        return (ones == 3'd1);
    endfunction

    // Binary index of a one-hot room; anything malformed maps to the cave
    function automatic logic [2:0] room_to_idx(input room_state_t st);
        logic [2:0] idx;
        case (st)
            ST_CAVE:   idx = ROOM_CAVE;
            ST_TUNNEL: idx = ROOM_TUNNEL;
            ST_RIVER:  idx = ROOM_RIVER;
            ST_STASH:  idx = ROOM_STASH;
            ST_DRAGON: idx = ROOM_DRAGON;
            ST_VAULT:  idx = ROOM_VAULT;
            ST_GRAVE:  idx = ROOM_GRAVE;
            default:   idx = ROOM_CAVE;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/location_fsm.sv
// Moore FSM tracking the player's room in the seven-room adventure.
// Direction requests are level-sensitive and resolved with fixed priority
// N > S > E > W among the moves that are legal from the current room.
// The dragon's den resolves after one cycle based on the sword flag V;
// the vault and graveyard are absorbing until reset.
// Optional feature: define LOCATION_FSM_STATE_IDX_EN to add the registered
// binary room index output state_idx[2:0].
module location_fsm
    import location_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       N,
    input  logic       S,
    input  logic       E,
    input  logic       W,
    input  logic       V,
    output logic       q0,
    output logic       q1,
    output logic       q2,
    output logic       q3,
    output logic       q4,
    output logic       q5,
    output logic       q6,
    output logic       SW,
    output logic       WIN,
    output logic       D
`ifdef LOCATION_FSM_STATE_IDX_EN
    ,
    output logic [2:0] state_idx
`endif
);

    room_state_t state_r;
    room_state_t state_next_s;

    // Next-room selection: legal moves tested in N, S, E, W priority order
    always_comb begin
        state_next_s = state_r;
        if (!is_onehot(state_r)) begin
            state_next_s = ST_CAVE;
        end else begin
            case (state_r)
                ST_CAVE: begin
                    if (E) begin
                        state_next_s = ST_TUNNEL;
                    end else begin
                        state_next_s = ST_CAVE;
                    end
                end
                ST_TUNNEL: begin
                    if (S) begin
                        state_next_s = ST_RIVER;
                    end else if (W) begin
                        state_next_s = ST_CAVE;
                    end else begin
                        state_next_s = ST_TUNNEL;
                    end
                end
                ST_RIVER: begin
                    if (N) begin
                        state_next_s = ST_TUNNEL;
                    end else if (E) begin
                        state_next_s = ST_DRAGON;
                    end else if (W) begin
                        state_next_s = ST_STASH;
                    end else begin
                        state_next_s = ST_RIVER;
                    end
                end
                ST_STASH: begin
                    if (E) begin
                        state_next_s = ST_RIVER;
                    end else begin
                        state_next_s = ST_STASH;
                    end
                end
                ST_DRAGON: begin
                    if (V) begin
                        state_next_s = ST_VAULT;
                    end else begin
                        state_next_s = ST_GRAVE;
                    end
                end
                ST_VAULT:  state_next_s = ST_VAULT;
                ST_GRAVE:  state_next_s = ST_GRAVE;
                default:   state_next_s = ST_CAVE;
            endcase
        end
    end

    // Room state register with synchronous reset to the cave
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_CAVE;
        end else begin
            state_r <= state_next_s;
        end
    end

`ifdef LOCATION_FSM_STATE_IDX_EN
    logic [2:0] idx_r;

    // Binary room index registered in step with the one-hot state
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_r <= ROOM_CAVE;
        end else begin
            idx_r <= room_to_idx(state_next_s);
        end
    end

    assign state_idx = idx_r;
`endif

    // Outputs are pure decodes of the state register
    assign q0  = state_r[ROOM_CAVE];
    assign q1  = state_r[ROOM_TUNNEL];
    assign q2  = state_r[ROOM_RIVER];
    assign q3  = state_r[ROOM_STASH];
    assign q4  = state_r[ROOM_DRAGON];
    assign q5  = state_r[ROOM_VAULT];
    assign q6  = state_r[ROOM_GRAVE];
    assign SW  = state_r[ROOM_STASH];
    assign WIN = state_r[ROOM_VAULT];
    assign D   = state_r[ROOM_GRAVE];

endmodule

// File: tb/tb_location_fsm.sv
// Self-checking bench for location_fsm: directed walk-throughs followed by
// randomized direction/sword/reset traffic, all checked against a room
// model built from a neighbour table.
module tb_location_fsm;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic N = 1'b0, S = 1'b0, E = 1'b0, W = 1'b0, V = 1'b0;
    logic q0, q1, q2, q3, q4, q5, q6, SW, WIN, D;
`ifdef LOCATION_FSM_STATE_IDX_EN
    logic [2:0] state_idx;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;
    int room = 0;

    // Neighbour table: [room][dir], dir 0=N 1=S 2=E 3=W, -1 = no exit
    int nbr [7][4] = '{
        '{-1, -1,  1, -1},
        '{-1,  2, -1,  0},
        '{ 1, -1,  4,  3},
        '{-1, -1,  2, -1},
        '{-1, -1, -1, -1},
        '{-1, -1, -1, -1},
        '{-1, -1, -1, -1}
    };

    location_fsm dut (
        .clock(clock), .reset(reset),
        .N(N), .S(S), .E(E), .W(W), .V(V),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6),
        .SW(SW), .WIN(WIN), .D(D)
`ifdef LOCATION_FSM_STATE_IDX_EN
        , .state_idx(state_idx)
`endif
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_next(input int cur, input logic n, s, e, w, v);
        logic req [4];
        req[0] = n; req[1] = s; req[2] = e; req[3] = w;
        if (cur == 4) return v ? 5 : 6;
        if (cur >= 5) return cur;
        for (int i = 0; i < 4; i++) begin
            if (req[i] && nbr[cur][i] >= 0) return nbr[cur][i];
        end
        return cur;
    endfunction

    task automatic compare_all(input string tag);
        logic [6:0] qv;
        logic [6:0] ev;
        qv = {q6, q5, q4, q3, q2, q1, q0};
        ev = 7'(1 << room);
        check_eq({tag, ".q"}, 32'(qv), 32'(ev));
        check_eq({tag, ".sw"}, 32'(SW), 32'(room == 3));
        check_eq({tag, ".win"}, 32'(WIN), 32'(room == 5));
        check_eq({tag, ".d"}, 32'(D), 32'(room == 6));
`ifdef LOCATION_FSM_STATE_IDX_EN
        check_eq({tag, ".idx"}, 32'(state_idx), 32'(room));
`endif
    endtask

    // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge
    task automatic step(input logic n, s, e, w, v, r, input string tag);
        N = n; S = s; E = e; W = w; V = v; reset = r;
        @(posedge clock);
        if (r) room = 0;
        else   room = model_next(room, n, s, e, w, v);
        #1;
        compare_all(tag);
    endtask

    // Directional shorthands: dirs = {N,S,E,W}
    task automatic go(input logic [3:0] dirs, input logic v, input string tag);
        step(dirs[3], dirs[2], dirs[1], dirs[0], v, 1'b0, tag);
    endtask

    initial begin
        // Reset hold
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst");
        go(4'b0000, 1'b0, "idle");
        check_eq("start_q0", 32'(q0), 32'd1);

        // Illegal directions from cave, then E
        go(4'b1000, 1'b0, "cave_n");
        go(4'b0100, 1'b0, "cave_s");
        go(4'b0001, 1'b0, "cave_w");
        go(4'b0010, 1'b0, "cave_e");
        check_eq("tunnel_q1", 32'(q1), 32'd1);

        // Path E,W,E,S,S,W then E,N,S
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst2");
        go(4'b0010, 1'b0, "p_e1");
        go(4'b0001, 1'b0, "p_w");
        go(4'b0010, 1'b0, "p_e2");
        go(4'b0100, 1'b0, "p_s1");
        go(4'b0100, 1'b0, "p_s2");
        go(4'b0001, 1'b0, "p_w2");
        check_eq("stash_sw", 32'(SW), 32'd1);
        go(4'b0010, 1'b0, "p_e3");
        go(4'b1000, 1'b0, "p_n");
        go(4'b0100, 1'b0, "p_s3");
        check_eq("river_q2", 32'(q2), 32'd1);

        // Dragon without sword -> graveyard, absorbing
        go(4'b0010, 1'b0, "dragon0");
        check_eq("dragon_q4", 32'(q4), 32'd1);
        go(4'b1111, 1'b0, "grave");
        check_eq("grave_d", 32'(D), 32'd1);
        go(4'b1000, 1'b1, "grave_n");
        go(4'b0010, 1'b1, "grave_e");
        check_eq("grave_hold", 32'(D), 32'd1);

        // Dragon with sword -> vault, then reset out of it
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst3");
        go(4'b0010, 1'b1, "v_e");
        go(4'b0100, 1'b1, "v_s");
        go(4'b0010, 1'b1, "v_dragon");
        go(4'b0000, 1'b1, "vault");
        check_eq("vault_win", 32'(WIN), 32'd1);
        go(4'b0001, 1'b0, "vault_hold");
        check_eq("vault_win_hold", 32'(WIN), 32'd1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "rst_vault");
        check_eq("back_q0", 32'(q0), 32'd1);

        // Priority N over E in river; E held three cycles from cave
        go(4'b0010, 1'b0, "pr_e");
        go(4'b0100, 1'b0, "pr_s");
        go(4'b1010, 1'b0, "pr_ne");
        check_eq("prio_q1", 32'(q1), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst4");
        for (int i = 0; i < 3; i++) go(4'b0010, 1'b0, "hold_e");
        check_eq("hold_q1", 32'(q1), 32'd1);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < 3),
                 1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < 3),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
